// File: rtl/uart_mem_bridge_pkg.sv
// rtl/uart_mem_bridge_pkg.sv - shared opcodes, status codes and FSM encoding for uart_mem_bridge
package uart_mem_bridge_pkg;

    localparam logic [7:0] OP_ADDR       = 8'h01;
    localparam logic [7:0] OP_LOAD       = 8'h02;
    localparam logic [7:0] OP_WRITE      = 8'h03;
    localparam logic [7:0] OP_READ       = 8'h04;
    localparam logic [7:0] OP_READ_REQ   = 8'h05;
    localparam logic [7:0] OP_COUNT      = 8'h06;
    localparam logic [7:0] OP_CONST      = 8'h07;
    localparam logic [7:0] OP_WRITE_INC  = 8'h08;
    localparam logic [7:0] OP_READ_BURST = 8'h09;

    localparam logic [7:0] ST_OK      = 8'h00;
    localparam logic [7:0] ST_UNKNOWN = 8'h01;
    localparam logic [7:0] ST_BUSY    = 8'h02;
    localparam logic [7:0] ST_BAD_LEN = 8'h03;
    localparam logic [7:0] ST_CSUM    = 8'h04;

    typedef enum logic [2:0] {
        S_RX,
        S_EXEC,
        S_WAIT_MEM,
        S_TX_LOAD,
        S_TX_STROBE,
        S_TX_WAIT
    } state_t;

    // Commands that touch the memory interface and must respect mem_busy
    function automatic logic is_mem_cmd(input logic [7:0] op);
        return (op == OP_WRITE) || (op == OP_READ_REQ) ||
               (op == OP_WRITE_INC) || (op == OP_READ_BURST);
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/uart_mem_bridge_fifo.sv
// rtl/uart_mem_bridge_fifo.sv - bridge_word_fifo: burst read buffer with push/pop/clear/empty
module bridge_word_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             pop_ok;

    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage array; no reset needed since reads are gated by count
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)   wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok) rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop_ok})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_mem_bridge.sv
// rtl/uart_mem_bridge.sv - UART command bridge to HyperRAM; optional UART_MEM_BRIDGE_CHECKSUM_EN
module uart_mem_bridge
    import uart_mem_bridge_pkg::*;
#(
    parameter int DATA_BYTES  = 4,
    parameter int ADDR_W      = 32,
    parameter int MAX_BURST   = 16,
    parameter int TIMEOUT_CYC = 24000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    rx_valid,
    input  logic [7:0]              rx_data,
    output logic                    tx_start,
    output logic [7:0]              tx_data,
    input  logic                    tx_ready,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [8*DATA_BYTES-1:0] mem_wr_d,
    output logic                    mem_wr_req,
    output logic                    mem_rd_req,
    output logic [5:0]              mem_rd_num,
    input  logic [8*DATA_BYTES-1:0] mem_rd_d,
    input  logic                    mem_rd_rdy,
    input  logic                    mem_busy,
    output logic [7:0]              err_count
);
    localparam int W = 8 * DATA_BYTES;
`ifdef UART_MEM_BRIDGE_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif
    localparam logic [7:0] LAST_IDX  = 8'(DATA_BYTES + CK);
    localparam logic [7:0] LAST_BYTE = 8'(DATA_BYTES - 1);

    state_t         state, state_nx;
    logic [7:0]     byte_cnt, cmd_r, resp_status, byte_idx, exec_status;
    logic [W-1:0]   payload_r, rd_word, counter, tx_shift, exec_word, fifo_rd_data;
    logic [31:0]    idle_cnt;
    logic [5:0]     rd_cnt, burst_n;
    logic [15:0]    tx_cnt, tx_total;
    logic [1:0]     wait_cnt;
    logic           resp_burst, exec_ok, load_status, load_data;
    logic           fifo_push, fifo_pop, fifo_clear, fifo_empty;
`ifdef UART_MEM_BRIDGE_CHECKSUM_EN
    logic [7:0]     rx_xor, rx_ck, tx_csum;
`endif

    assign burst_n     = payload_r[5:0];
    assign mem_rd_num  = (cmd_r == OP_READ_BURST) ? burst_n : 6'd1;
    assign load_status = (tx_cnt == 16'd0);
`ifdef UART_MEM_BRIDGE_CHECKSUM_EN
    assign load_data   = !load_status && (tx_cnt != tx_total - 16'd1);
`else
    assign load_data   = !load_status;
`endif
    assign fifo_push   = (state == S_WAIT_MEM) && mem_rd_rdy;
    assign fifo_clear  = (state == S_EXEC);
    assign fifo_pop    = (state == S_TX_LOAD) && resp_burst && !fifo_empty &&
                         (load_status || (load_data && byte_idx == LAST_BYTE));

    bridge_word_fifo #(.DEPTH(MAX_BURST), .WIDTH(W)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .clear   (fifo_clear),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data (mem_rd_d),
        .rd_data (fifo_rd_data),
        .empty   (fifo_empty)
    );

    // Command decode: status and response word for the frame held in cmd_r/payload_r
    always_comb begin
        exec_status = ST_OK;
        exec_word   = '0;
        case (cmd_r)
            OP_ADDR, OP_LOAD:                     exec_word = payload_r;
            OP_WRITE, OP_READ_REQ, OP_WRITE_INC:  exec_word = W'(cmd_r);
            OP_READ:                              exec_word = rd_word;
            OP_COUNT:                             exec_word = counter;
            OP_CONST:                             exec_word = W'(259);
            OP_READ_BURST:                        exec_word = '0;
            default:                              exec_status = ST_UNKNOWN;
        endcase
        if (exec_status == ST_OK && cmd_r == OP_READ_BURST &&
            (burst_n == 6'd0 || int'(burst_n) > MAX_BURST))
            exec_status = ST_BAD_LEN;
        if (exec_status == ST_OK && is_mem_cmd(cmd_r) && mem_busy)
            exec_status = ST_BUSY;
`ifdef UART_MEM_BRIDGE_CHECKSUM_EN
        if (rx_xor != rx_ck) exec_status = ST_CSUM;
`endif
        exec_ok = (exec_status == ST_OK);
        if (!exec_ok) exec_word = '0;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= S_RX;
        else       state <= state_nx;
    end

    // Next-state logic plus the single-cycle strobes
    always_comb begin
        state_nx   = state;
        tx_start   = 1'b0;
        mem_wr_req = 1'b0;
        mem_rd_req = 1'b0;
        case (state)
            S_RX:        if (rx_valid && byte_cnt == LAST_IDX) state_nx = S_EXEC;
            S_EXEC: begin
                mem_wr_req = exec_ok && (cmd_r == OP_WRITE || cmd_r == OP_WRITE_INC);
                mem_rd_req = exec_ok && (cmd_r == OP_READ_REQ || cmd_r == OP_READ_BURST);
                state_nx   = mem_rd_req ? S_WAIT_MEM : S_TX_LOAD;
            end
            S_WAIT_MEM:  if (mem_rd_rdy && (rd_cnt + 6'd1) == mem_rd_num) state_nx = S_TX_LOAD;
            S_TX_LOAD:   state_nx = S_TX_STROBE;
            S_TX_STROBE: if (tx_ready) begin
                tx_start = 1'b1;
                state_nx = S_TX_WAIT;
            end
            S_TX_WAIT:   if (wait_cnt == 2'd2 && tx_ready)
                state_nx = (tx_cnt == tx_total) ? S_RX : S_TX_LOAD;
            default:     state_nx = S_RX;
        endcase
    end

    // Datapath: frame capture, timeout, command side effects and response serialisation
    always_ff @(posedge clk) begin
        if (reset) begin
            byte_cnt <= '0; cmd_r <= '0; payload_r <= '0; idle_cnt <= '0;
            rd_word <= '0; counter <= '0; mem_addr <= '0; mem_wr_d <= '0;
            err_count <= '0; resp_status <= '0; resp_burst <= 1'b0; tx_shift <= '0;
            tx_cnt <= '0; tx_total <= '0; byte_idx <= '0; rd_cnt <= '0;
            wait_cnt <= '0; tx_data <= '0;
`ifdef UART_MEM_BRIDGE_CHECKSUM_EN
            rx_xor <= '0; rx_ck <= '0; tx_csum <= '0;
`endif
        end else begin
            case (state)
                S_RX: begin
                    if (rx_valid) begin
                        idle_cnt <= '0;
                        if (byte_cnt == 8'd0) begin
                            cmd_r <= rx_data;
`ifdef UART_MEM_BRIDGE_CHECKSUM_EN
                            rx_xor <= rx_data;
                        end else if (byte_cnt == LAST_IDX) begin
                            rx_ck <= rx_data;
`endif
                        end else begin
                            payload_r <= {payload_r[W-9:0], rx_data};
`ifdef UART_MEM_BRIDGE_CHECKSUM_EN
                            rx_xor <= rx_xor ^ rx_data;
`endif
                        end
                        byte_cnt <= (byte_cnt == LAST_IDX) ? 8'd0 : byte_cnt + 8'd1;
                    end else if (byte_cnt != 8'd0) begin
                        if (idle_cnt == 32'(TIMEOUT_CYC - 1)) begin
                            byte_cnt  <= '0;
                            idle_cnt  <= '0;
                            err_count <= sat_inc(err_count);
                        end else begin
                            idle_cnt <= idle_cnt + 32'd1;
                        end
                    end
                end
                S_EXEC: begin
                    resp_status <= exec_status;
                    tx_shift    <= exec_word;
                    resp_burst  <= exec_ok && (cmd_r == OP_READ_BURST);
                    tx_cnt      <= '0;
                    byte_idx    <= '0;
                    rd_cnt      <= '0;
                    tx_total    <= (exec_ok && cmd_r == OP_READ_BURST) ?
                                   16'(1 + CK) + 16'(burst_n) * 16'(DATA_BYTES) :
                                   16'(1 + DATA_BYTES + CK);
                    if (!exec_ok) begin
                        err_count <= sat_inc(err_count);
                    end else begin
                        case (cmd_r)
                            OP_ADDR:      mem_addr <= payload_r[ADDR_W-1:0];
                            OP_LOAD:      mem_wr_d <= payload_r;
                            OP_COUNT:     counter  <= counter + W'(1);
                            OP_WRITE_INC: mem_addr <= mem_addr + ADDR_W'(1);
                            default:      ;
                        endcase
                    end
                end
                S_WAIT_MEM: if (mem_rd_rdy) begin
                    rd_cnt <= rd_cnt + 6'd1;
                    if (cmd_r == OP_READ_REQ) rd_word <= mem_rd_d;
                end
                S_TX_LOAD: begin
                    tx_cnt <= tx_cnt + 16'd1;
                    if (load_status) begin
                        tx_data <= resp_status;
`ifdef UART_MEM_BRIDGE_CHECKSUM_EN
                        tx_csum <= resp_status;
`endif
                        if (resp_burst) tx_shift <= fifo_rd_data;
                    end else if (load_data) begin
                        tx_data  <= tx_shift[W-1 -: 8];
                        tx_shift <= tx_shift << 8;
`ifdef UART_MEM_BRIDGE_CHECKSUM_EN
                        tx_csum  <= tx_csum ^ tx_shift[W-1 -: 8];
`endif
                        if (byte_idx == LAST_BYTE) begin
                            byte_idx <= '0;
                            if (resp_burst && !fifo_empty) tx_shift <= fifo_rd_data;
                        end else begin
                            byte_idx <= byte_idx + 8'd1;
                        end
                    end
`ifdef UART_MEM_BRIDGE_CHECKSUM_EN
                    else begin
                        tx_data <= tx_csum;
                    end
`endif
                end
                S_TX_STROBE: wait_cnt <= '0;
                S_TX_WAIT:   if (wait_cnt != 2'd2) wait_cnt <= wait_cnt + 2'd1;
                default: ;
            endcase
        end
    end

endmodule
